// File: rtl/cpx_accum_dump.sv
// Complex integrate-and-dump: sums len I/Q sample pairs, then presents the
// block sums with a sticky overflow flag on a valid/ready output handshake.
module cpx_accum_dump #(
    parameter int i_bits   = 24,
    parameter int q_bits   = 24,
    parameter int acc_bits = 32,
    parameter int len      = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_axis_i_tvalid,
    input  logic                m_axis_q_tvalid,
    input  logic [i_bits-1:0]   i,
    input  logic [q_bits-1:0]   q,
    output logic                m_axis_tready,
    output logic                s_axis_tvalid,
    input  logic                s_axis_tready,
    output logic [acc_bits-1:0] sum_i,
    output logic [acc_bits-1:0] sum_q,
    output logic                ovf
);

    localparam int cnt_bits = (len > 1) ? $clog2(len) : 1;
    localparam logic [cnt_bits-1:0] last_cnt = cnt_bits'(len - 1);

    typedef enum logic {
        ACCUM,
        DUMP
    } state_t;

    state_t state, next_state;

    logic signed [acc_bits-1:0] acc_i, acc_q;
    logic signed [acc_bits-1:0] i_ext, q_ext;
    logic signed [acc_bits-1:0] new_i, new_q;
    logic [cnt_bits-1:0]        count;
    logic                       sticky;
    logic                       ovf_i, ovf_q;
    logic                       accept, last;

    assign i_ext = acc_bits'($signed(i));
    assign q_ext = acc_bits'($signed(q));
    assign new_i = acc_i + i_ext;
    assign new_q = acc_q + q_ext;

    // Signed overflow: both operands share a sign that the wrapped result lacks.
    assign ovf_i = (acc_i[acc_bits-1] == i_ext[acc_bits-1]) &&
                   (new_i[acc_bits-1] != acc_i[acc_bits-1]);
    assign ovf_q = (acc_q[acc_bits-1] == q_ext[acc_bits-1]) &&
                   (new_q[acc_bits-1] != acc_q[acc_bits-1]);

    assign accept = m_axis_i_tvalid && m_axis_q_tvalid && m_axis_tready && (state == ACCUM);
    assign last   = accept && (count == last_cnt);

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (last) next_state = DUMP;
            DUMP:    if (s_axis_tready) next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Ready stays low through reset so the first edge after release raises it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tready <= 1'b0;
        end else begin
            m_axis_tready <= (next_state == ACCUM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_i         <= '0;
            acc_q         <= '0;
            count         <= '0;
            sticky        <= 1'b0;
            s_axis_tvalid <= 1'b0;
            sum_i         <= '0;
            sum_q         <= '0;
            ovf           <= 1'b0;
        end else begin
            if (last) begin
                sum_i         <= new_i;
                sum_q         <= new_q;
                ovf           <= sticky | ovf_i | ovf_q;
                s_axis_tvalid <= 1'b1;
                acc_i         <= '0;
                acc_q         <= '0;
                count         <= '0;
                sticky        <= 1'b0;
            end else if (accept) begin
                acc_i  <= new_i;
                acc_q  <= new_q;
                count  <= count + 1'b1;
                sticky <= sticky | ovf_i | ovf_q;
            end
            if (state == DUMP && s_axis_tready) begin
                s_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpx_accum_dump.sv
// Scoreboard bench for cpx_accum_dump: two instances (len=4/acc 32 and
// len=8/acc 26) driven by directed and random I/Q streams.
module tb_cpx_accum_dump;

    localparam int LEN_A = 4;
    localparam int LEN_B = 8;
    localparam int W_A   = 32;
    localparam int W_B   = 26;

    typedef struct {
        longint si;
        longint sq;
        bit     ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vi [2];
    logic        in_vq [2];
    logic        in_sr [2];
    logic [23:0] in_i  [2];
    logic [23:0] in_q  [2];
    logic        out_tr [2];
    logic        out_tv [2];
    logic        out_ovf [2];
    logic [31:0] sia, sqa;
    logic [25:0] sib, sqb;

    bit          drv_rst;
    bit          drv_vi [2];
    bit          drv_vq [2];
    bit          drv_sr [2];
    logic [23:0] drv_i  [2];
    logic [23:0] drv_q  [2];

    longint macc_i [2];
    longint macc_q [2];
    int     mcount [2];
    bit     msticky [2];
    bit     mdump [2];
    bit     mready [2];
    exp_t   qa [$];
    exp_t   qb [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpx_accum_dump #(.i_bits(24), .q_bits(24), .acc_bits(W_A), .len(LEN_A)) dut_a (
        .clk(clk), .rst(rst),
        .m_axis_i_tvalid(in_vi[0]), .m_axis_q_tvalid(in_vq[0]),
        .i(in_i[0]), .q(in_q[0]),
        .m_axis_tready(out_tr[0]), .s_axis_tvalid(out_tv[0]), .s_axis_tready(in_sr[0]),
        .sum_i(sia), .sum_q(sqa), .ovf(out_ovf[0])
    );

    cpx_accum_dump #(.i_bits(24), .q_bits(24), .acc_bits(W_B), .len(LEN_B)) dut_b (
        .clk(clk), .rst(rst),
        .m_axis_i_tvalid(in_vi[1]), .m_axis_q_tvalid(in_vq[1]),
        .i(in_i[1]), .q(in_q[1]),
        .m_axis_tready(out_tr[1]), .s_axis_tvalid(out_tv[1]), .s_axis_tready(in_sr[1]),
        .sum_i(sib), .sum_q(sqb), .ovf(out_ovf[1])
    );

    function automatic int lenOf(int d);
        return (d == 0) ? LEN_A : LEN_B;
    endfunction

    function automatic int widthOf(int d);
        return (d == 0) ? W_A : W_B;
    endfunction

    function automatic longint wrapv(longint x, int w);
        longint m;
        m = x & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    function automatic bit addOverflows(longint a, longint b, int w);
        longint exact;
        exact = a + b;
        return (exact > (longint'(1) << (w - 1)) - 1) || (exact < -(longint'(1) << (w - 1)));
    endfunction

    function automatic longint getSum(int d, bit isq);
        if (d == 0) return isq ? longint'($signed(sqa)) : longint'($signed(sia));
        return isq ? longint'($signed(sqb)) : longint'($signed(sib));
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clearModel(int d);
        macc_i[d]  = 0;
        macc_q[d]  = 0;
        mcount[d]  = 0;
        msticky[d] = 1'b0;
        mdump[d]   = 1'b0;
        mready[d]  = 1'b0;
        if (d == 0) qa.delete();
        else qb.delete();
    endtask

    // Reference: exact integer sums wrapped to the accumulator width, one
    // dump per len accepted pairs, ready low while a dump is outstanding.
    task automatic modelStep(int d);
        exp_t   e;
        longint si, sq;
        int     w;
        w = widthOf(d);
        if (drv_rst) begin
            clearModel(d);
            return;
        end
        if (drv_vi[d] && drv_vq[d] && mready[d]) begin
            si = longint'($signed(drv_i[d]));
            sq = longint'($signed(drv_q[d]));
            msticky[d] = msticky[d] | addOverflows(macc_i[d], si, w) | addOverflows(macc_q[d], sq, w);
            macc_i[d] = wrapv(macc_i[d] + si, w);
            macc_q[d] = wrapv(macc_q[d] + sq, w);
            mcount[d]++;
            if (mcount[d] == lenOf(d)) begin
                e.si = macc_i[d];
                e.sq = macc_q[d];
                e.ovf = msticky[d];
                if (d == 0) qa.push_back(e);
                else qb.push_back(e);
                macc_i[d]  = 0;
                macc_q[d]  = 0;
                mcount[d]  = 0;
                msticky[d] = 1'b0;
                mdump[d]   = 1'b1;
            end
        end else if (mdump[d] && drv_sr[d]) begin
            mdump[d] = 1'b0;
        end
        mready[d] = !mdump[d];
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        rst = drv_rst;
        for (int d = 0; d < 2; d++) begin
            in_vi[d] = drv_vi[d];
            in_vq[d] = drv_vq[d];
            in_sr[d] = drv_sr[d];
            in_i[d]  = drv_i[d];
            in_q[d]  = drv_q[d];
        end
        if (!drv_rst) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("tready_%0d", d), longint'(out_tr[d]), longint'(mready[d]));
                checkOutput($sformatf("tvalid_%0d", d), longint'(out_tv[d]), longint'(mdump[d]));
            end
        end
        for (int d = 0; d < 2; d++) modelStep(d);
    endtask

    task automatic setIdle();
        for (int d = 0; d < 2; d++) begin
            drv_vi[d] = 1'b0;
            drv_vq[d] = 1'b0;
            drv_sr[d] = 1'b1;
            drv_i[d]  = '0;
            drv_q[d]  = '0;
        end
    endtask

    task automatic cycleOn(int d, bit vi, bit vq, int iv, int qv, bit sr);
        setIdle();
        drv_vi[d] = vi;
        drv_vq[d] = vq;
        drv_i[d]  = 24'(iv);
        drv_q[d]  = 24'(qv);
        drv_sr[d] = sr;
        applyStimulus();
    endtask

    task automatic idleCycles(int n);
        setIdle();
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    // Asserts reset between clock edges and checks the outputs cleared at once.
    task automatic resetNow();
        @(negedge clk);
        #2;
        rst = 1'b1;
        drv_rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("async_tvalid_%0d", d), longint'(out_tv[d]), 0);
            checkOutput($sformatf("async_tready_%0d", d), longint'(out_tr[d]), 0);
            checkOutput($sformatf("async_ovf_%0d", d), longint'(out_ovf[d]), 0);
            checkOutput($sformatf("async_sum_i_%0d", d), getSum(d, 1'b0), 0);
            checkOutput($sformatf("async_sum_q_%0d", d), getSum(d, 1'b1), 0);
        end
        idleCycles(2);
        drv_rst = 1'b0;
    endtask

    task automatic monitorOne(int d);
        exp_t e;
        int   depth;
        if (!out_tv[d]) return;
        depth = (d == 0) ? qa.size() : qb.size();
        if (depth == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_dump_%0d actual=valid required=no dump", d);
            return;
        end
        e = (d == 0) ? qa[0] : qb[0];
        checkOutput($sformatf("sum_i_%0d", d), getSum(d, 1'b0), e.si);
        checkOutput($sformatf("sum_q_%0d", d), getSum(d, 1'b1), e.sq);
        checkOutput($sformatf("ovf_%0d", d), longint'(out_ovf[d]), longint'(e.ovf));
        if (in_sr[d]) begin
            if (d == 0) void'(qa.pop_front());
            else void'(qb.pop_front());
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            monitorOne(0);
            monitorOne(1);
        end
    end

    initial begin
        int drain;
        rst = 1'b1;
        drv_rst = 1'b1;
        setIdle();
        for (int d = 0; d < 2; d++) begin
            in_vi[d] = 1'b0;
            in_vq[d] = 1'b0;
            in_sr[d] = 1'b1;
            in_i[d]  = '0;
            in_q[d]  = '0;
            clearModel(d);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset_tready_%0d", d), longint'(out_tr[d]), 0);
            checkOutput($sformatf("reset_tvalid_%0d", d), longint'(out_tv[d]), 0);
            checkOutput($sformatf("reset_sum_i_%0d", d), getSum(d, 1'b0), 0);
        end
        idleCycles(2);
        drv_rst = 1'b0;
        idleCycles(2);

        $display("[TB] consecutive block");
        for (int k = 1; k <= 4; k++) cycleOn(0, 1, 1, k, -k, 1);
        idleCycles(3);

        $display("[TB] gapped valids with single-valid cycles");
        cycleOn(0, 1, 1, 1, -1, 1);
        idleCycles(1);
        cycleOn(0, 1, 0, 77, 88, 1);
        cycleOn(0, 1, 1, 2, -2, 1);
        idleCycles(1);
        cycleOn(0, 0, 1, 55, 66, 1);
        cycleOn(0, 1, 1, 3, -3, 1);
        idleCycles(1);
        cycleOn(0, 1, 1, 4, -4, 1);
        idleCycles(3);

        $display("[TB] downstream stall");
        for (int k = 0; k < 4; k++) cycleOn(0, 1, 1, 7, 100 - k, 0);
        for (int k = 0; k < 3; k++) cycleOn(0, 1, 1, 9, 9, 0);
        cycleOn(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) cycleOn(0, 1, 1, 1, 1, 1);
        idleCycles(2);

        $display("[TB] wrap and overflow on narrow accumulator");
        for (int k = 0; k < 8; k++) cycleOn(1, 1, 1, 8388607, 0, 1);
        idleCycles(1);
        for (int k = 0; k < 8; k++) cycleOn(1, 1, 1, 1, 0, 1);
        idleCycles(2);

        $display("[TB] reset mid-block");
        cycleOn(0, 1, 1, 3, 3, 1);
        cycleOn(0, 1, 1, 3, 3, 1);
        resetNow();
        idleCycles(1);
        for (int k = 0; k < 4; k++) cycleOn(0, 1, 1, 5, 5, 1);
        idleCycles(2);

        $display("[TB] reset while dumping");
        for (int k = 0; k < 4; k++) cycleOn(0, 1, 1, -6, 11, 0);
        cycleOn(0, 0, 0, 0, 0, 0);
        resetNow();
        for (int k = 0; k < 4; k++) cycleOn(0, 1, 1, 2, 2, 1);
        idleCycles(2);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                drv_vi[d] = ($urandom_range(0, 3) != 0);
                drv_vq[d] = ($urandom_range(0, 3) != 0);
                drv_sr[d] = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 3))
                    0:       begin drv_i[d] = 24'h7FFFFF; drv_q[d] = 24'h800000; end
                    1:       begin drv_i[d] = 24'h800000; drv_q[d] = 24'h7FFFFF; end
                    default: begin drv_i[d] = 24'($urandom); drv_q[d] = 24'($urandom); end
                endcase
            end
            applyStimulus();
        end

        setIdle();
        drain = 0;
        while ((qa.size() != 0 || qb.size() != 0) && drain < 50) begin
            applyStimulus();
            drain++;
        end
        idleCycles(2);
        checkOutput("drain_a", qa.size(), 0);
        checkOutput("drain_b", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpx_accum_dump.md
CPX_ACCUM_DUMP -- requirements
Module: cpx_accum_dump

Interface
REQ-001 SHALL have parameter i_bits, default 24, meaning width of signed input I sample.
REQ-002 SHALL have parameter q_bits, default 24, meaning width of signed input Q sample.
REQ-003 SHALL have parameter acc_bits, default 32, meaning width of each signed accumulator and sum output; acc_bits >= max(i_bits, q_bits).
REQ-004 SHALL have parameter len, default 64, meaning samples per dump; len >= 1.
REQ-005 SHALL have one clock and an asynchronous, active-high reset:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have the remaining ports:
- m_axis_i_tvalid  input  1  I sample valid from upstream.
- m_axis_q_tvalid  input  1  Q sample valid from upstream.
- i  input  i_bits  signed I sample.
- q  input  q_bits  signed Q sample.
- m_axis_tready  output  1  block can accept a sample.
- s_axis_tvalid  output  1  dump result valid.
- s_axis_tready  input  1  downstream accepts dump.
- sum_i  output  acc_bits  signed I sum.
- sum_q  output  acc_bits  signed Q sum.
- ovf  output  1  any I or Q partial sum of the dumped block overflowed.

Function
REQ-007 SHALL implement a two-state FSM: ACCUM and DUMP.
REQ-008 SHALL drive m_axis_tready=1 in ACCUM and 0 in DUMP, registered.
REQ-009 SHALL accept a sample only on an edge where m_axis_i_tvalid, m_axis_q_tvalid and m_axis_tready are all 1.
- One valid high alone: ignored, no state change.
REQ-010 SHALL sign-extend each accepted i and q to acc_bits and add them to acc_i and acc_q respectively.
- Arithmetic: two's complement, wraps modulo 2^acc_bits.
REQ-011 SHALL count accepted samples 0..len-1.
- On the accept that makes the count len: load sum_i/sum_q with acc plus the current sample, load ovf, set s_axis_tvalid=1, clear acc_i/acc_q/count/sticky overflow, and enter DUMP.
- Latency: outputs valid on the edge that accepts the len-th sample.
REQ-012 SHALL detect overflow per addition: operands of equal sign, result of the other sign.
- Sets a sticky flag for the current block.
- ovf includes the overflow of the final addition.
REQ-013 SHALL, in DUMP, hold s_axis_tvalid, sum_i, sum_q and ovf stable until s_axis_tready=1.
- Handshake edge: clear s_axis_tvalid, return to ACCUM, and set m_axis_tready=1 for the next cycle.
REQ-014 SHALL keep m_axis_tready=0 for at least one cycle per block, even when s_axis_tready is held 1.
- Maximum throughput: len samples per len+1 cycles.
REQ-015 SHALL, with len=1, dump every accepted sample unchanged (sign-extended).
REQ-016 SHALL ignore s_axis_tready while in ACCUM.

Reset
REQ-017 SHALL, on rst=1 at any time including mid-block or in DUMP, immediately:
- enter ACCUM;
- clear acc_i, acc_q, count and sticky overflow;
- drive s_axis_tvalid=0, sum_i=0, sum_q=0, ovf=0 and m_axis_tready=0.
REQ-018 SHALL drive m_axis_tready=1 on the first rising clk edge after rst deasserts; a partial block is discarded.

Verification
REQ-019 len=4, s_axis_tready=1, inputs (1,-1),(2,-2),(3,-3),(4,-4) on consecutive cycles -> single dump with sum_i=10, sum_q=-10, ovf=0; m_axis_tready low exactly one cycle.
REQ-020 len=4, valids gapped (high every other cycle), and one cycle with only m_axis_i_tvalid=1 -> only double-valid samples summed; same sums as REQ-019.
REQ-021 len=4, s_axis_tready=0 for 3 cycles after dump -> s_axis_tvalid, sum_i, sum_q stable and m_axis_tready=0 throughout; samples presented then are not counted.
REQ-022 acc_bits=26, len=8, i=8388607 every sample -> sum_i=-8 (wrapped), ovf=1; next block with i=1 -> sum_i=8, ovf=0.
REQ-023 len=4, rst pulsed after 2 accepted samples -> no dump; next 4 samples (5,5) -> sum_i=20, sum_q=20.
REQ-024 rst asserted while in DUMP -> s_axis_tvalid=0 and sums=0 without a clk edge; normal operation resumes after deassert.
